// File: rtl/prog_feeder_pkg.sv
// prog_feeder_pkg: shared state type, core opcodes and idle word for the program feeder
package prog_feeder_pkg;
  typedef enum logic [1:0] {LOAD, RUN, DONE} state_t;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_JUMP  = 4'h7;
  localparam logic [7:0] IDLE_INSTR_DEF = 8'h20;
endpackage

// File: rtl/prog_feeder_mem.sv
// prog_feeder_mem: instruction and operand arrays, one write port and one registered read port
module prog_feeder_mem #(
  parameter int DEPTH = 256,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wr_instr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rd_instr,
  output logic [7:0]    rd_data
);
  logic [7:0] imem [DEPTH];
  logic [7:0] dmem [DEPTH];
  // no reset on the arrays or read registers so they stay block-RAM shaped
  always_ff @(posedge clk) begin
    if (we) begin
      imem[waddr] <= wr_instr;
      dmem[waddr] <= wr_data;
    end
    rd_instr <= imem[raddr];
    rd_data <= dmem[raddr];
  end
endmodule

// File: rtl/prog_feeder.sv
// prog_feeder: holds the host-loaded program and feeds the core's fetch port while a run is active
module prog_feeder
  import prog_feeder_pkg::*;
#(
  parameter int          DEPTH       = 256,
  parameter int          AW          = $clog2(DEPTH),
  parameter logic [7:0]  IDLE_INSTR  = IDLE_INSTR_DEF,
  parameter int          STALL_LIMIT = 16,
  parameter logic [15:0] MAX_CYCLES  = 16'hFFFF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_addr,
  input  logic [7:0]    ld_instr,
  input  logic [7:0]    ld_data,
  input  logic          start,
  input  logic          stop,
  input  logic          clear,
  input  logic [7:0]    pc,
  output logic [7:0]    instruction,
  output logic [7:0]    data_in,
  output logic          running,
  output logic          done,
  output logic          stalled,
  output logic          timeout,
  output logic          oob,
  output logic [15:0]   cycle_count
);
  localparam int SW = $clog2(STALL_LIMIT + 1);
  state_t state, state_nxt;
  logic [7:0] prev_pc, mem_instr, mem_data;
  logic [SW-1:0] stall_cnt, stall_nxt;
  logic [15:0] cc_nxt;
  logic fetch_valid, hit_oob, hit_stall, hit_time, run_exit, enter_run, wr_en;
  prog_feeder_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk(clk),
    .we(wr_en),
    .waddr(ld_addr),
    .wr_instr(ld_instr),
    .wr_data(ld_data),
    .raddr(pc[AW-1:0]),
    .rd_instr(mem_instr),
    .rd_data(mem_data)
  );
  // run-exit detection, evaluated against the pc presented this cycle
  always_comb begin
    hit_oob = 32'(pc) >= DEPTH;
    stall_nxt = (pc != prev_pc) ? '0 : (&stall_cnt ? stall_cnt : stall_cnt + 1'b1);
    hit_stall = 32'(stall_nxt) >= STALL_LIMIT;
    cc_nxt = cycle_count + 16'd1;
    hit_time = cc_nxt >= MAX_CYCLES;
    run_exit = (state == RUN) && (stop || hit_oob || hit_stall || hit_time);
    enter_run = (state != RUN) && start;
    wr_en = ld_valid && ld_ready && (32'(ld_addr) < DEPTH);
  end
  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= LOAD;
    else state <= state_nxt;
  end
  // next state: start wins over clear in DONE, run ends on any exit condition
  always_comb begin
    state_nxt = (state == LOAD) ? (start ? RUN : LOAD) :
                (state == RUN)  ? (run_exit ? DONE : RUN) :
                start ? RUN : (clear ? LOAD : DONE);
  end
  // outputs: fetched word is shown only while a fetch from a live run is held
  always_comb begin
    ld_ready = state == LOAD;
    running = state == RUN;
    done = state == DONE;
    instruction = fetch_valid ? mem_instr : IDLE_INSTR;
    data_in = fetch_valid ? mem_data : 8'd0;
  end
  // run bookkeeping: stall tracking, cycle budget and the single end-of-run flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_valid <= 1'b0;
      prev_pc <= 8'd0;
      stall_cnt <= '0;
      cycle_count <= 16'd0;
      stalled <= 1'b0;
      timeout <= 1'b0;
      oob <= 1'b0;
    end else begin
      fetch_valid <= (state == RUN) && !run_exit;
      if (enter_run) begin
        prev_pc <= pc;
        stall_cnt <= '0;
        cycle_count <= 16'd0;
        stalled <= 1'b0;
        timeout <= 1'b0;
        oob <= 1'b0;
      end else if (state == RUN) begin
        prev_pc <= pc;
        stall_cnt <= stall_nxt;
        cycle_count <= cc_nxt;
        oob <= !stop && hit_oob;
        stalled <= !stop && !hit_oob && hit_stall;
        timeout <= !stop && !hit_oob && !hit_stall && hit_time;
      end
    end
  end
endmodule

// File: tb/tb_prog_feeder.sv
// tb_prog_feeder: table vectors, corner sequences and a randomized run against a program-level model
module tb_prog_feeder;
  localparam int DEP = 16;
  localparam int S_LIM = 16;
  localparam int A_MAX = 40;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ld_valid = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0;
  logic [3:0] ld_addr = '0;
  logic [7:0] ld_instr = '0, ld_data = '0, pc = '0;
  logic rdy_a, run_a, done_a, stl_a, to_a, oob_a;
  logic rdy_b, run_b, done_b, stl_b, to_b, oob_b;
  logic [7:0] ins_a, dat_a, ins_b, dat_b;
  logic [15:0] cc_a, cc_b;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  prog_feeder #(.DEPTH(DEP), .STALL_LIMIT(S_LIM), .MAX_CYCLES(16'(A_MAX))) u_a (
    .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_ready(rdy_a), .ld_addr(ld_addr),
    .ld_instr(ld_instr), .ld_data(ld_data), .start(start), .stop(stop), .clear(clear), .pc(pc),
    .instruction(ins_a), .data_in(dat_a), .running(run_a), .done(done_a), .stalled(stl_a),
    .timeout(to_a), .oob(oob_a), .cycle_count(cc_a));

  prog_feeder #(.DEPTH(DEP), .STALL_LIMIT(S_LIM), .MAX_CYCLES(16'd10)) u_b (
    .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_ready(rdy_b), .ld_addr(ld_addr),
    .ld_instr(ld_instr), .ld_data(ld_data), .start(start), .stop(stop), .clear(clear), .pc(pc),
    .instruction(ins_b), .data_in(dat_b), .running(run_b), .done(done_b), .stalled(stl_b),
    .timeout(to_b), .oob(oob_b), .cycle_count(cc_b));

  // program-level reference for u_a: the run is the list of pcs seen since start
  int m_mode;
  logic [7:0] m_im [DEP];
  logic [7:0] m_dm [DEP];
  logic [7:0] m_ins, m_dat;
  logic m_stl, m_to, m_oob;
  int m_cc;
  int m_pcs [$];

  task automatic m_reset();
    m_mode = 0; m_ins = 8'h20; m_dat = 8'h00;
    m_stl = 0; m_to = 0; m_oob = 0; m_cc = 0; m_pcs.delete();
  endtask

  task automatic m_enter();
    m_mode = 1; m_stl = 0; m_to = 0; m_oob = 0; m_cc = 0;
    m_pcs.delete(); m_pcs.push_back(int'(pc));
  endtask

  function automatic int m_trail();
    int t = 0;
    for (int k = m_pcs.size() - 1; k > 0 && m_pcs[k] == m_pcs[k-1]; k--) t++;
    return t;
  endfunction

  task automatic m_step();
    if (m_mode == 0) begin
      if (ld_valid) begin m_im[ld_addr] = ld_instr; m_dm[ld_addr] = ld_data; end
      if (start) m_enter();
    end else if (m_mode == 1) begin
      m_cc++;
      m_pcs.push_back(int'(pc));
      if (stop || int'(pc) >= DEP || m_trail() >= S_LIM || m_cc >= A_MAX) begin
        m_oob = !stop && int'(pc) >= DEP;
        m_stl = !stop && !m_oob && m_trail() >= S_LIM;
        m_to = !stop && !m_oob && !m_stl;
        m_mode = 2; m_ins = 8'h20; m_dat = 8'h00;
      end else begin
        m_ins = m_im[pc[3:0]]; m_dat = m_dm[pc[3:0]];
      end
    end else if (start) m_enter();
    else if (clear) m_mode = 0;
  endtask

  always @(negedge reset) m_reset();
  always @(posedge clk) if (reset) m_step();

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] a, input logic [7:0] i, input logic [7:0] d,
                       input logic st, input logic sp, input logic cl, input logic [7:0] p);
    ld_valid = v; ld_addr = a; ld_instr = i; ld_data = d; start = st; stop = sp; clear = cl; pc = p;
  endtask

  typedef struct {
    logic v; logic [3:0] a; logic [7:0] i, d; logic st, sp, cl; logic [7:0] p;
    logic [7:0] ei, ed; logic er, edn, erdy;
  } vec_t;
  vec_t tbl [14];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] p;
    int hold;
    tbl[0]  = '{1'b1, 4'd0, 8'h10, 8'h05, 1'b0, 1'b0, 1'b0, 8'd0, 8'h20, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 4'd1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0, 8'h20, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 4'd2, 8'h3A, 8'h77, 1'b0, 1'b0, 1'b0, 8'd0, 8'h20, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 4'd3, 8'h2B, 8'h99, 1'b0, 1'b0, 1'b0, 8'd0, 8'h20, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'd0, 8'h20, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0, 8'h10, 8'h05, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'd1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'd2, 8'h3A, 8'h77, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'd3, 8'h2B, 8'h99, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'd2, 8'h20, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 4'd0, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, 8'd0, 8'h20, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 4'd4, 8'h44, 8'h55, 1'b1, 1'b0, 1'b0, 8'd4, 8'h20, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'd4, 8'h44, 8'h55, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'd4, 8'h20, 8'h00, 1'b0, 1'b1, 1'b0};
    m_reset();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_ins", ins_a, 8'h20); chk("rst_dat", dat_a, 8'h00); chk("rst_rdy", rdy_a, 1'b1);
    chk("rst_run", run_a, 1'b0); chk("rst_cc", cc_a, 16'd0);
    chk("rst_flags", {stl_a, to_a, oob_a, done_a}, 4'd0);
    @(negedge clk) reset = 1'b1;
    for (int k = 0; k < DEP; k++) begin
      drive(1'b1, 4'(k), 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0, 8'd0);
      @(negedge clk);
      chk("fill_rdy", rdy_a, 1'b1);
    end
    for (int r = 0; r < 14; r++) begin
      drive(tbl[r].v, tbl[r].a, tbl[r].i, tbl[r].d, tbl[r].st, tbl[r].sp, tbl[r].cl, tbl[r].p);
      @(negedge clk);
      chk($sformatf("tbl%0d_ins", r), ins_a, tbl[r].ei);
      chk($sformatf("tbl%0d_dat", r), dat_a, tbl[r].ed);
      chk($sformatf("tbl%0d_run", r), run_a, tbl[r].er);
      chk($sformatf("tbl%0d_done", r), done_a, tbl[r].edn);
      chk($sformatf("tbl%0d_rdy", r), rdy_a, tbl[r].erdy);
    end
    // stall: pc held at 3 from the start edge on
    drive(1'b0, 4'd0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd3);
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    chk("stall_pre_run", run_a, 1'b1); chk("stall_pre_ins", ins_a, 8'h2B);
    @(negedge clk);
    chk("stall_done", done_a, 1'b1); chk("stall_flag", stl_a, 1'b1);
    chk("stall_ins", ins_a, 8'h20); chk("stall_dat", dat_a, 8'h00);
    chk("stall_other", {to_a, oob_a}, 2'b00); chk("stall_cc", cc_a, 16'd16);
    // out of range pc
    drive(1'b0, 4'd0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    chk("oob_rerun_flags", {run_a, stl_a, to_a, oob_a}, 4'b1000); chk("oob_rerun_cc", cc_a, 16'd0);
    drive(1'b0, 4'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 8'h20);
    @(negedge clk);
    chk("oob_done", done_a, 1'b1); chk("oob_flag", oob_a, 1'b1); chk("oob_ins", ins_a, 8'h20);
    drive(1'b0, 4'd0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 8'h20);
    @(negedge clk);
    drive(1'b0, 4'd0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0, 8'h20);
    @(negedge clk);
    chk("prio_done", done_a, 1'b1); chk("prio_oob", oob_a, 1'b0);
    // timeout on the short-budget instance
    drive(1'b0, 4'd0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0; pc = 8'(k);
      if (k == 10) begin chk("to_pre_run", run_b, 1'b1); chk("to_pre_cc", cc_b, 16'd9); end
    end
    @(negedge clk);
    chk("to_done", done_b, 1'b1); chk("to_flag", to_b, 1'b1); chk("to_cc", cc_b, 16'd10);
    chk("to_other", {stl_b, oob_b}, 2'b00); chk("to_ins", ins_b, 8'h20);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rerun_run", run_b, 1'b1); chk("rerun_cc", cc_b, 16'd0);
    chk("rerun_flags", {stl_b, to_b, oob_b, done_b}, 4'd0);
    chk("a_ignores_start", run_a, 1'b1);
    // async reset between edges while running
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("areset_run", run_a, 1'b0); chk("areset_rdy", rdy_a, 1'b1);
    chk("areset_ins", ins_a, 8'h20); chk("areset_cc", cc_a, 16'd0);
    @(negedge clk) reset = 1'b1;
    drive(1'b0, 4'd0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd2);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("retain_ins", ins_a, 8'h3A); chk("retain_dat", dat_a, 8'h77);
    // randomized traffic against the model
    p = 8'd2; hold = 0;
    for (int c = 0; c < 3000; c++) begin
      chk("rnd_ins", ins_a, m_ins); chk("rnd_dat", dat_a, m_dat);
      chk("rnd_run", run_a, m_mode == 1); chk("rnd_done", done_a, m_mode == 2);
      chk("rnd_rdy", rdy_a, m_mode == 0); chk("rnd_cc", cc_a, 16'(m_cc));
      chk("rnd_flags", {stl_a, to_a, oob_a}, {m_stl, m_to, m_oob});
      if (hold > 0) hold--;
      else if ($urandom_range(63) == 0) hold = 20;
      else case ($urandom_range(9))
        0, 1, 2, 3, 4, 5: p = 8'((int'(p) + 1) % DEP);
        6, 7: p = p;
        8: p = 8'($urandom_range(DEP - 1));
        default: p = 8'($urandom_range(31));
      endcase
      drive(1'($urandom), 4'($urandom), 8'($urandom), 8'($urandom),
            $urandom_range(7) == 0, $urandom_range(23) == 0, $urandom_range(5) == 0, p);
      @(negedge clk);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
